ip4_rtl_tlb: RTL and testbench

- Data TLB responder for the DSE address-translation request interface. The DSE issues one virtual page number (VPN) per request in its AG stage.
- The block looks it up fully-associatively and returns a registered PFN/attribute/exception response one cycle later, in the DSE TAG stage.
- Also provides a refill write port (indexed or random) and a multi-cycle per-thread / global flush engine.

---
 rtl/ip4_rtl_tlb.sv | 139 +++++++++++++
 tb/tb_ip4_rtl_tlb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ip4_rtl_tlb.sv
// ip4_rtl_tlb: fully-associative data TLB with 1-cycle lookup, refill port and flush engine
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_*  / rsp_*               lookup request (AG stage) and registered response (TAG stage)
//   wr_*                         refill write, indexed or at the random replacement pointer
//   flush_en/all/tid, flush_busy per-thread or global invalidation, one entry per cycle
module ip4_rtl_tlb #(
  parameter int NUM_ENTRY  = 16,
  parameter int NUM_THREAD = 4,
  parameter int WID_VPN    = 20,
  parameter int WID_PFN    = 20,
  parameter int NUM_WIRED  = 2,
  localparam int TW = $clog2(NUM_THREAD),
  localparam int EW = $clog2(NUM_ENTRY)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_en,
  output logic               req_rdy,
  input  logic [WID_VPN-1:0] req_vpn,
  input  logic [TW-1:0]      req_tid,
  input  logic               req_k,
  input  logic               req_st,
  output logic               rsp_en,
  output logic               rsp_hit,
  output logic [WID_PFN-1:0] rsp_pfn,
  output logic               rsp_c,
  output logic [1:0]         rsp_exc,
  output logic [TW-1:0]      rsp_tid,
  input  logic               wr_en,
  input  logic               wr_rand,
  input  logic [EW-1:0]      wr_idx,
  input  logic [WID_VPN-1:0] wr_vpn,
  input  logic [WID_PFN-1:0] wr_pfn,
  input  logic [TW-1:0]      wr_tid,
  input  logic               wr_v,
  input  logic               wr_g,
  input  logic               wr_k,
  input  logic               wr_w,
  input  logic               wr_c,
  input  logic               flush_en,
  input  logic               flush_all,
  input  logic [TW-1:0]      flush_tid,
  output logic               flush_busy
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state;
  logic [NUM_ENTRY-1:0] entV, entG, entK, entW, entC, match;
  logic [TW-1:0] entTid [NUM_ENTRY];
  logic [WID_VPN-1:0] entVpn [NUM_ENTRY];
  logic [WID_PFN-1:0] entPfn [NUM_ENTRY];
  logic [EW-1:0] rPtr, fIdx, wrSel, hitIdx;
  logic [TW-1:0] fTid;
  logic fAll, wrGo, flushHit, hitAny, privFail, modFail, acc, okHit;
  logic [1:0] excNext;
  assign req_rdy  = ~flush_busy;
  assign acc      = req_en && req_rdy;
  assign wrGo     = wr_en && !flush_busy;
  assign wrSel    = wr_rand ? rPtr : wr_idx;
  assign flushHit = fAll || (!entG[fIdx] && entTid[fIdx] == fTid);
  // Only the valid bits need reset; tag/data are qualified by them.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) entV <= '0;
    else begin
      if (wrGo) entV[wrSel] <= wr_v;
      if (flush_busy && flushHit) entV[fIdx] <= 1'b0;
    end
  always_ff @(posedge clk)
    if (wrGo) begin
      entG[wrSel]   <= wr_g;
      entK[wrSel]   <= wr_k;
      entW[wrSel]   <= wr_w;
      entC[wrSel]   <= wr_c;
      entTid[wrSel] <= wr_tid;
      entVpn[wrSel] <= wr_vpn;
      entPfn[wrSel] <= wr_pfn;
    end
  // Replacement pointer cycles over the non-wired entries, freezing while it is consumed.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rPtr <= EW'(NUM_WIRED);
    else if (!(wrGo && wr_rand)) rPtr <= (rPtr == EW'(NUM_ENTRY-1)) ? EW'(NUM_WIRED) : rPtr + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      flush_busy <= 1'b0;
      fIdx       <= '0;
      fAll       <= 1'b0;
      fTid       <= '0;
    end else begin
      case (state)
        IDLE: if (flush_en) begin
          state      <= FLUSH;
          flush_busy <= 1'b1;
          fIdx       <= '0;
          fAll       <= flush_all;
          fTid       <= flush_tid;
        end
        FLUSH: begin
          fIdx <= fIdx + 1'b1;
          if (fIdx == EW'(NUM_ENTRY-1)) begin
            state      <= IDLE;
            flush_busy <= 1'b0;
          end
        end
      endcase
    end
  for (genvar i = 0; i < NUM_ENTRY; i++) begin : g_match
    assign match[i] = entV[i] && entVpn[i] == req_vpn && (entG[i] || entTid[i] == req_tid);
  end
  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hitAny = 1'b0;
    hitIdx = '0;
    for (int i = NUM_ENTRY-1; i >= 0; i--)
      if (match[i]) begin
        hitAny = 1'b1;
        hitIdx = EW'(i);
      end
  end
  assign privFail = entK[hitIdx] && !req_k;
  assign modFail  = req_st && !entW[hitIdx];
  assign okHit    = acc && hitAny && !privFail && !modFail;
  assign excNext  = !hitAny ? 2'd1 : privFail ? 2'd2 : modFail ? 2'd3 : 2'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_en  <= 1'b0;
      rsp_hit <= 1'b0;
      rsp_pfn <= '0;
      rsp_c   <= 1'b0;
      rsp_exc <= 2'd0;
      rsp_tid <= '0;
    end else begin
      rsp_en  <= acc;
      rsp_hit <= okHit;
      rsp_pfn <= okHit ? entPfn[hitIdx] : '0;
      rsp_c   <= okHit && entC[hitIdx];
      rsp_exc <= acc ? excNext : 2'd0;
      rsp_tid <= acc ? req_tid : '0;
    end
endmodule

// File: tb/tb_ip4_rtl_tlb.sv
// tb_ip4_rtl_tlb: directed and randomized checks of ip4_rtl_tlb against a behavioural model
module tb_ip4_rtl_tlb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_en = 0, req_k = 0, req_st = 0, req_rdy, rsp_en, rsp_hit, rsp_c, flush_busy;
  logic [19:0] req_vpn = 0, wr_vpn = 0, wr_pfn = 0, rsp_pfn;
  logic [1:0] req_tid = 0, rsp_tid, rsp_exc, wr_tid = 0, flush_tid = 0;
  logic wr_en = 0, wr_rand = 0, wr_v = 0, wr_g = 0, wr_k = 0, wr_w = 0, wr_c = 0;
  logic [3:0] wr_idx = 0;
  logic flush_en = 0, flush_all = 0;
  int checks = 0, errors = 0;
  typedef struct {bit v, g, k, w, c; int tid, vpn, pfn;} ent_t;
  ent_t mEnt [16];
  int mPtr, mCnt;
  bit mBusy;
  always #5 clk = ~clk;
  ip4_rtl_tlb dut (
    .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_rdy(req_rdy), .req_vpn(req_vpn),
    .req_tid(req_tid), .req_k(req_k), .req_st(req_st), .rsp_en(rsp_en), .rsp_hit(rsp_hit),
    .rsp_pfn(rsp_pfn), .rsp_c(rsp_c), .rsp_exc(rsp_exc), .rsp_tid(rsp_tid), .wr_en(wr_en),
    .wr_rand(wr_rand), .wr_idx(wr_idx), .wr_vpn(wr_vpn), .wr_pfn(wr_pfn), .wr_tid(wr_tid),
    .wr_v(wr_v), .wr_g(wr_g), .wr_k(wr_k), .wr_w(wr_w), .wr_c(wr_c), .flush_en(flush_en),
    .flush_all(flush_all), .flush_tid(flush_tid), .flush_busy(flush_busy)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", flush_busy, 0);
    check("rst_rdy", req_rdy, 1);
    check("rst_rsp_en", rsp_en, 0);
    check("rst_rsp_exc", rsp_exc, 0);
    foreach (mEnt[i]) mEnt[i].v = 0;
    mPtr = 2;
    mBusy = 0;
    mCnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  // Model: response from current contents; a flush's net effect is applied at once since
  // contents are unobservable (no lookups, no writes) until it finishes.
  task automatic tick();
    bit expEn, expHit, expC;
    int m, expExc, expPfn, expTid, tgt;
    expEn = req_en && !mBusy;
    m = -1;
    for (int i = 0; i < 16; i++)
      if (m < 0 && mEnt[i].v && mEnt[i].vpn == int'(req_vpn) && (mEnt[i].g || mEnt[i].tid == int'(req_tid))) m = i;
    expHit = 0; expPfn = 0; expC = 0; expTid = req_tid;
    if (m < 0) expExc = 1;
    else if (mEnt[m].k && !req_k) expExc = 2;
    else if (req_st && !mEnt[m].w) expExc = 3;
    else begin
      expExc = 0; expHit = 1; expPfn = mEnt[m].pfn; expC = mEnt[m].c;
    end
    if (wr_en && !mBusy) begin
      tgt = wr_rand ? mPtr : int'(wr_idx);
      mEnt[tgt] = '{wr_v, wr_g, wr_k, wr_w, wr_c, int'(wr_tid), int'(wr_vpn), int'(wr_pfn)};
    end
    if (!(wr_en && wr_rand && !mBusy)) mPtr = (mPtr == 15) ? 2 : mPtr + 1;
    if (mBusy) begin
      mCnt--;
      if (mCnt == 0) mBusy = 0;
    end else if (flush_en) begin
      mBusy = 1;
      mCnt = 16;
      foreach (mEnt[i]) if (flush_all || (!mEnt[i].g && mEnt[i].tid == int'(flush_tid))) mEnt[i].v = 0;
    end
    @(posedge clk);
    #1;
    check("rsp_en", rsp_en, expEn);
    if (expEn) begin
      check("rsp_hit", rsp_hit, expHit);
      check("rsp_exc", rsp_exc, expExc);
      check("rsp_tid", rsp_tid, expTid);
      if (expExc < 2) begin
        check("rsp_pfn", rsp_pfn, expPfn);
        check("rsp_c", rsp_c, expC);
      end
    end
    check("flush_busy", flush_busy, mBusy);
    check("req_rdy", req_rdy, !mBusy);
  endtask
  task automatic setWr(int idx, int vpn, int pfn, int tid, bit g, bit k, bit w, bit c);
    wr_en = 1; wr_rand = 0; wr_idx = 4'(idx); wr_vpn = 20'(vpn); wr_pfn = 20'(pfn);
    wr_tid = 2'(tid); wr_v = 1; wr_g = g; wr_k = k; wr_w = w; wr_c = c;
  endtask
  task automatic wrIdx(int idx, int vpn, int pfn, int tid, bit g, bit k, bit w, bit c);
    setWr(idx, vpn, pfn, tid, g, k, w, c);
    tick();
    wr_en = 0;
  endtask
  task automatic look(int vpn, int tid, bit k, bit st);
    req_en = 1; req_vpn = 20'(vpn); req_tid = 2'(tid); req_k = k; req_st = st;
    tick();
    req_en = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int busyCnt;
    #1;
    doReset();
    check("idle_rdy", req_rdy, 1);
    wrIdx(3, 'h12345, 'h00ABC, 1, 0, 0, 1, 1);
    look('h12345, 1, 0, 0);
    check("tp_hit", rsp_hit, 1);
    check("tp_pfn", rsp_pfn, 'hABC);
    check("tp_c", rsp_c, 1);
    check("tp_exc0", rsp_exc, 0);
    look('h12345, 2, 0, 0);
    check("tp_other_tid", rsp_exc, 1);
    wrIdx(3, 'h12345, 'h00ABC, 1, 1, 0, 1, 1);
    look('h12345, 2, 0, 0);
    check("tp_global_hit", rsp_hit, 1);
    wrIdx(5, 'h2222, 'h777, 0, 0, 1, 0, 0);
    look('h2222, 0, 0, 0);
    check("tp_priv", rsp_exc, 2);
    look('h2222, 0, 1, 1);
    check("tp_modify", rsp_exc, 3);
    look('h2222, 0, 1, 0);
    check("tp_kload_hit", rsp_hit, 1);
    wrIdx(9, 'h3333, 'h111, 2, 0, 0, 1, 0);
    wrIdx(8, 'h3333, 'h222, 2, 0, 0, 1, 0);
    look('h3333, 2, 0, 1);
    check("tp_lowest_idx", rsp_pfn, 'h222);
    setWr(6, 'h4444, 'h555, 3, 0, 0, 1, 0);
    req_en = 1; req_vpn = 'h4444; req_tid = 3; req_k = 0; req_st = 0;
    tick();
    wr_en = 0;
    check("tp_wr_same_cycle", rsp_exc, 1);
    tick();
    req_en = 0;
    check("tp_wr_next_cycle", rsp_hit, 1);
    doReset();
    look('h12345, 1, 0, 0);
    check("tp_reset_clears", rsp_exc, 1);
    wrIdx(0, 'h100, 'h900, 0, 1, 0, 1, 0);
    wrIdx(1, 'h101, 'h901, 0, 1, 0, 1, 0);
    for (int n = 0; n < 30; n++) begin
      wr_en = 1; wr_rand = 1; wr_vpn = 20'('h200 + n); wr_pfn = 20'('h800 + n);
      wr_tid = 0; wr_v = 1; wr_g = 1; wr_k = 0; wr_w = 1; wr_c = 1;
      tick();
      wr_en = 0;
      tick();
    end
    wr_rand = 0;
    look('h100, 0, 0, 0);
    check("tp_wired0", rsp_pfn, 'h900);
    look('h101, 0, 0, 0);
    check("tp_wired1", rsp_pfn, 'h901);
    for (int n = 0; n < 30; n++) look('h200 + n, 0, 0, 0);
    doReset();
    wrIdx(4, 'h400, 'hA0, 0, 0, 0, 1, 0);
    wrIdx(5, 'h401, 'hA1, 0, 0, 0, 1, 0);
    wrIdx(6, 'h500, 'hB0, 1, 0, 0, 1, 0);
    wrIdx(7, 'h600, 'hC0, 0, 1, 0, 1, 0);
    flush_en = 1; flush_all = 0; flush_tid = 0;
    look('h400, 0, 0, 0);
    flush_en = 0;
    check("tp_flush_same_cycle", rsp_hit, 1);
    busyCnt = flush_busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      req_en = (i % 3 == 0); req_vpn = 'h500; req_tid = 1;
      wr_en = (i == 2); wr_idx = 4; wr_rand = 0; wr_vpn = 'h999;
      tick();
      if (flush_busy) busyCnt++;
    end
    req_en = 0; wr_en = 0;
    check("tp_flush_len", busyCnt, 16);
    look('h400, 0, 0, 0);
    check("tp_flush_tid0", rsp_exc, 1);
    look('h401, 0, 0, 0);
    check("tp_flush_tid0b", rsp_exc, 1);
    look('h500, 1, 0, 0);
    check("tp_flush_tid1", rsp_hit, 1);
    look('h600, 0, 0, 0);
    check("tp_flush_global", rsp_hit, 1);
    look('h999, 0, 0, 0);
    check("tp_wr_ignored_busy", rsp_exc, 1);
    flush_en = 1; flush_all = 1;
    tick();
    flush_en = 0;
    for (int i = 0; i < 4; i++) tick();
    doReset();
    check("tp_midflush_busy", flush_busy, 0);
    look('h500, 1, 0, 0);
    check("tp_midflush_inval", rsp_exc, 1);
    look('h600, 0, 0, 0);
    for (int n = 0; n < 700; n++) begin
      req_en = ($urandom_range(3) != 0); req_vpn = 20'('h10 + $urandom_range(7));
      req_tid = 2'($urandom); req_k = 1'($urandom); req_st = 1'($urandom);
      wr_en = ($urandom_range(3) == 0); wr_rand = 1'($urandom); wr_idx = 4'($urandom);
      wr_vpn = 20'('h10 + $urandom_range(7)); wr_pfn = 20'($urandom); wr_tid = 2'($urandom);
      wr_v = ($urandom_range(7) != 0); wr_g = ($urandom_range(3) == 0);
      wr_k = 1'($urandom); wr_w = 1'($urandom); wr_c = 1'($urandom);
      flush_en = ($urandom_range(39) == 0); flush_all = 1'($urandom); flush_tid = 2'($urandom);
      tick();
    end
    req_en = 0; wr_en = 0; flush_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
